pipe_ibuf: RTL and testbench
============================

# pipe_ibuf

Instruction buffer between the IF stage and the ID stage. Captures each fetched instruction and its PC from IF through the `buf_we`/`buf_wack` handshake, queues them in a small in-order FIFO, and presents the oldest entry to ID with a valid/ready handshake. A `purge` input discards every queued entry when EX redirects the PC, so wrong-path instructions never reach ID.

## Interface
- `INST_L`, 32, instruction width
- `PC_L`, 32, PC width
- `DEPTH`, 4, number of entries; a power of two, at least 2
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-low reset.
- `buf_we` in 1: IF write request, level; held until `buf_wack` is seen.
- `inst_in` in INST_L: instruction from IF.
- `pc_in` in PC_L: PC of `inst_in`.
- `buf_wack` out 1: one-cycle pulse that acknowledges an accepted write.
- `purge` in 1: flush all entries (PC redirect).
- `id_ready` in 1: ID consumes the head entry this cycle.
- `id_valid` out 1: head entry is valid.
- `id_inst` out INST_L: head instruction.
- `id_pc` out PC_L: head PC.
- `full` out 1: count == DEPTH.
- `count` out log2(DEPTH)+1: current number of entries.

## Operation
- Storage: `DEPTH`-entry array of {inst, pc}, with write pointer `wp`, read pointer `rp` (log2(DEPTH) bits, wrap modulo DEPTH) and a `count` register.
- Write accept: `wr_ok = buf_we & ~full & ~buf_wack & ~purge`.
  - On accept, store {inst_in, pc_in} at `wp` and increment `wp`.
  - `buf_wack` is registered: it goes high the cycle after acceptance, for exactly one cycle.
  - The `~buf_wack` term blocks a second write of the same word while IF is still dropping `buf_we`.
- Read: `rd_ok = id_valid & id_ready & ~purge`. On a read, increment `rp`.
- Count update:
  - +1 on write only.
  - −1 on read only.
  - Unchanged when both a write and a read occur in the same cycle.
- Full: while full, `buf_we` is held pending and no `buf_wack` is issued. A same-cycle read does not free a slot for that cycle's write, because `full` is the registered value.
- Empty: `id_valid = 0`, and `id_ready` is ignored.
- Purge:
  - Next cycle: `wp = rp = 0` and `count = 0`.
  - A write pending in the purge cycle is dropped with no `buf_wack`; IF abandons it on redirect.
  - A read in the purge cycle does not occur.
  - Purge has priority over every other event.
- Reset, including mid-operation, in the cycle `rst = 0`:
  - `wp`, `rp`, `count` cleared to 0.
  - `buf_wack = 0`, `id_valid = 0`, `full = 0`.
  - `id_inst` and `id_pc` read as 0.
  - Array contents are don't-care.
  - Reset overrides purge.
- No pass-through: an entry written in cycle N is visible to ID no earlier than cycle N+1.

## Timing
- Everything updates on the rising edge of `clk`.
- Write-to-valid latency: 1 cycle when the buffer is empty.
- `buf_wack` latency: 1 cycle after the accepting edge.
- Outputs:
  - `id_inst` and `id_pc` are a combinational read of `mem[rp]`, forced to 0 when `count == 0`.
  - `id_valid = (count != 0)`.
- Sustained throughput: one write every 2 cycles, limited by the `buf_wack` turnaround; one read per cycle.
- Purge takes effect at the next edge; the earliest possible write after purge is accepted in the cycle after the purge cycle.

## Structure
- Width constants (`INST_L`, `PC_L`) and the default depth belong in the shared `riscv_const.v` include, as `IBUF_DEPTH`.
- One sub-module is natural: `sync_fifo` (generic array, pointers and count, with flush). `pipe_ibuf` wraps it with the IF write handshake and the ID-facing outputs.
- No other state machine is needed; the handshake is the single `buf_wack` register.

## Test plan
- Reset, then write {0x00000013, pc 0x0} → `buf_wack` high for exactly 1 cycle at N+1; `id_valid = 1` at N+1 with `id_inst = 0x00000013` and `id_pc = 0x0`; `count = 1`.
- With `id_ready = 0`, write 4 instructions at pcs 0x0, 0x4, 0x8, 0xC → `full = 1`, `count = 4`. A fifth `buf_we` gets no `buf_wack` until `id_ready` pulses once, then the fifth write is accepted next. Reads come out in order 0x0 through 0xC, then the fifth entry.
- Hold `buf_we` high for 6 cycles with the same data → exactly 3 writes accepted (alternating accept/ack); no duplicate beyond the handshake rule.
- Buffer holding 3 entries; assert `purge` in the same cycle as `buf_we` and `id_ready` → next cycle `count = 0` and `id_valid = 0`; no `buf_wack`; nothing consumed.
- Write and read in the same cycle with `count = 2` → `count` stays 2; the head advances to the next PC.
- Drive `rst = 0` for one cycle mid-stream with `count = 3` and `buf_wack` high → next cycle every output is 0. A subsequent write of pc 0x1000 appears as the head.

Source files
------------

// File: rtl/pipe_ibuf_pkg.sv
// Shared widths and default depth for the IF->ID instruction buffer.
package pipe_ibuf_pkg;

  localparam int IBUF_INST_L = 32;
  localparam int IBUF_PC_L   = 32;
  localparam int IBUF_DEPTH  = 4;

endpackage

// File: rtl/pipe_ibuf_sync_fifo.sv
// Generic in-order FIFO: storage array, wrapping pointers, count and a flush that empties it.
module sync_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [AW:0]      count_q, count_d;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (wr_en) wp_d = wp_q + 1'b1;
      if (rd_en) rp_d = rp_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Contents need no reset; count gates every observation of them.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem_q[wp_q] <= wr_data;
  end

  assign rd_data = mem_q[rp_q];
  assign count   = count_q;
  assign full    = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/pipe_ibuf.sv
// IF->ID instruction buffer: IF write handshake with one-cycle ack, in-order queue, purge on redirect.
module pipe_ibuf
  import pipe_ibuf_pkg::*;
#(
  parameter  int INST_L = IBUF_INST_L,
  parameter  int PC_L   = IBUF_PC_L,
  parameter  int DEPTH  = IBUF_DEPTH,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              buf_we,
  input  logic [INST_L-1:0] inst_in,
  input  logic [PC_L-1:0]   pc_in,
  output logic              buf_wack,
  input  logic              purge,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [INST_L-1:0] id_inst,
  output logic [PC_L-1:0]   id_pc,
  output logic              full,
  output logic [AW:0]       count
);

  localparam int EW = INST_L + PC_L;

  logic          wack_q, wack_d;
  logic          wr_ok, rd_ok;
  logic [EW-1:0] head;

  // The ack term stops IF's still-high buf_we from being taken twice.
  assign wr_ok    = buf_we & ~full & ~wack_q & ~purge;
  assign rd_ok    = id_valid & id_ready & ~purge;
  assign wack_d   = wr_ok;

  always_ff @(posedge clk) begin
    if (!rst) wack_q <= 1'b0;
    else      wack_q <= wack_d;
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (purge),
    .wr_en   (wr_ok),
    .wr_data ({inst_in, pc_in}),
    .rd_en   (rd_ok),
    .rd_data (head),
    .count   (count),
    .full    (full)
  );

  assign buf_wack = wack_q;
  assign id_valid = (count != '0);
  assign id_inst  = id_valid ? head[EW-1:PC_L] : '0;
  assign id_pc    = id_valid ? head[PC_L-1:0]  : '0;

endmodule

// File: tb/tb_pipe_ibuf.sv
// Scenario bench for pipe_ibuf: expected entries are queued as writes are driven and popped as ID reads.
module tb_pipe_ibuf;

  localparam int INST_L = 32;
  localparam int PC_L   = 32;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              buf_we = 1'b0;
  logic [INST_L-1:0] inst_in = '0;
  logic [PC_L-1:0]   pc_in = '0;
  logic              buf_wack;
  logic              purge = 1'b0;
  logic              id_ready = 1'b0;
  logic              id_valid;
  logic [INST_L-1:0] id_inst;
  logic [PC_L-1:0]   id_pc;
  logic              full;
  logic [CW-1:0]     count;

  int nAssert = 0;
  int nFail   = 0;
  logic [63:0] sbQ[$];

  pipe_ibuf #(.INST_L(INST_L), .PC_L(PC_L), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .buf_we(buf_we), .inst_in(inst_in), .pc_in(pc_in),
    .buf_wack(buf_wack), .purge(purge), .id_ready(id_ready), .id_valid(id_valid),
    .id_inst(id_inst), .id_pc(id_pc), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b0; buf_we = 1'b0; purge = 1'b0; id_ready = 1'b0;
    tick();
    rst = 1'b1;
    sbQ.delete();
  endtask

  task automatic writeWord(input logic [31:0] inst, input logic [31:0] pc);
    int waited;
    inst_in = inst; pc_in = pc; buf_we = 1'b1;
    sbQ.push_back({inst, pc});
    waited = 0;
    tick();
    while (buf_wack !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    nAssert++;
    if (buf_wack !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL write_ack_timeout pc=%h: buf_wack=%b required 1", pc, buf_wack);
    end
    buf_we = 1'b0;
    tick();
  endtask

  task automatic drainOne(input string name);
    logic [63:0] exp;
    nAssert++;
    if (sbQ.size() == 0) begin
      nFail++;
      $display("[TB] FAIL %s: scoreboard empty, id_valid=%b", name, id_valid);
    end else begin
      exp = sbQ.pop_front();
      if (id_valid !== 1'b1 || {id_inst, id_pc} !== exp) begin
        nFail++;
        $display("[TB] FAIL %s: valid=%b inst=%h pc=%h required valid=1 inst=%h pc=%h",
                 name, id_valid, id_inst, id_pc, exp[63:32], exp[31:0]);
      end
    end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    nAssert++;
    if ({buf_wack, id_valid, full, count, id_inst, id_pc} !== '0) begin
      nFail++;
      $display("[TB] FAIL reset_state: wack=%b valid=%b full=%b count=%0d inst=%h pc=%h required all 0",
               buf_wack, id_valid, full, count, id_inst, id_pc);
    end
  endtask

  task automatic test_single_write();
    doReset();
    inst_in = 32'h0000_0013; pc_in = 32'h0; buf_we = 1'b1;
    sbQ.push_back({32'h0000_0013, 32'h0});
    tick();
    nAssert++;
    if (buf_wack !== 1'b1 || id_valid !== 1'b1 || id_inst !== 32'h13 || id_pc !== 32'h0 || count !== CW'(1)) begin
      nFail++;
      $display("[TB] FAIL single_write: wack=%b valid=%b inst=%h pc=%h count=%0d required 1 1 00000013 0 1",
               buf_wack, id_valid, id_inst, id_pc, count);
    end
    buf_we = 1'b0;
    tick();
    nAssert++;
    if (buf_wack !== 1'b0 || count !== CW'(1)) begin
      nFail++;
      $display("[TB] FAIL single_wack_pulse: wack=%b count=%0d required 0 1", buf_wack, count);
    end
    drainOne("single_read");
  endtask

  task automatic test_fill_and_full();
    doReset();
    for (int i = 0; i < DEPTH; i++) writeWord(32'h1000 + i, 32'(i * 4));
    nAssert++;
    if (full !== 1'b1 || count !== CW'(DEPTH)) begin
      nFail++;
      $display("[TB] FAIL fill_full: full=%b count=%0d required 1 %0d", full, count, DEPTH);
    end
    inst_in = 32'h2000; pc_in = 32'h10; buf_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      nAssert++;
      if (buf_wack !== 1'b0 || count !== CW'(DEPTH)) begin
        nFail++;
        $display("[TB] FAIL full_hold_%0d: wack=%b count=%0d required 0 %0d", i, buf_wack, count, DEPTH);
      end
    end
    sbQ.push_back({32'h2000, 32'h10});
    drainOne("full_read_pc0");
    nAssert++;
    if (buf_wack !== 1'b0 || count !== CW'(DEPTH - 1) || full !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL full_read_no_write: wack=%b count=%0d full=%b required 0 %0d 0",
               buf_wack, count, full, DEPTH - 1);
    end
    tick();
    nAssert++;
    if (buf_wack !== 1'b1 || count !== CW'(DEPTH)) begin
      nFail++;
      $display("[TB] FAIL fifth_accept: wack=%b count=%0d required 1 %0d", buf_wack, count, DEPTH);
    end
    buf_we = 1'b0;
    tick();
    for (int i = 0; i < DEPTH; i++) drainOne($sformatf("full_drain_%0d", i));
    nAssert++;
    if (id_valid !== 1'b0 || count !== '0 || id_inst !== '0) begin
      nFail++;
      $display("[TB] FAIL drained_empty: valid=%b count=%0d inst=%h required 0 0 0", id_valid, count, id_inst);
    end
  endtask

  task automatic test_hold_we();
    int acks;
    doReset();
    acks = 0;
    inst_in = 32'hABCD_0001; pc_in = 32'h40; buf_we = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      nAssert++;
      if (buf_wack !== ((i % 2) == 0)) begin
        nFail++;
        $display("[TB] FAIL hold_we_cycle_%0d: wack=%b required %0d", i, buf_wack, (i % 2) == 0);
      end
      if (buf_wack === 1'b1) begin
        acks++;
        sbQ.push_back({32'hABCD_0001, 32'h40});
      end
    end
    buf_we = 1'b0;
    tick();
    nAssert++;
    if (acks != 3 || count !== CW'(3)) begin
      nFail++;
      $display("[TB] FAIL hold_we_total: acks=%0d count=%0d required 3 3", acks, count);
    end
  endtask

  task automatic test_purge();
    // Relies on the 3 entries left by test_hold_we.
    inst_in = 32'hDEAD; pc_in = 32'h80; buf_we = 1'b1; id_ready = 1'b1; purge = 1'b1;
    tick();
    buf_we = 1'b0; id_ready = 1'b0; purge = 1'b0;
    sbQ.delete();
    nAssert++;
    if (count !== '0 || id_valid !== 1'b0 || buf_wack !== 1'b0 || id_pc !== '0) begin
      nFail++;
      $display("[TB] FAIL purge: count=%0d valid=%b wack=%b pc=%h required 0 0 0 0",
               count, id_valid, buf_wack, id_pc);
    end
    tick();
    nAssert++;
    if (buf_wack !== 1'b0 || count !== '0) begin
      nFail++;
      $display("[TB] FAIL purge_no_late_ack: wack=%b count=%0d required 0 0", buf_wack, count);
    end
    writeWord(32'h77, 32'h84);
    drainOne("after_purge_head");
  endtask

  task automatic test_back_to_back();
    doReset();
    writeWord(32'h20, 32'h20);
    writeWord(32'h24, 32'h24);
    inst_in = 32'h28; pc_in = 32'h28; buf_we = 1'b1;
    sbQ.push_back({32'h28, 32'h28});
    drainOne("rw_head_0x20");
    buf_we = 1'b0;
    nAssert++;
    if (count !== CW'(2) || buf_wack !== 1'b1 || id_pc !== 32'h24) begin
      nFail++;
      $display("[TB] FAIL rw_same_cycle: count=%0d wack=%b pc=%h required 2 1 00000024", count, buf_wack, id_pc);
    end
    tick();
    drainOne("rw_drain_0x24");
    drainOne("rw_drain_0x28");
  endtask

  task automatic test_reset_mid();
    doReset();
    writeWord(32'h1, 32'h100);
    writeWord(32'h2, 32'h104);
    inst_in = 32'h3; pc_in = 32'h108; buf_we = 1'b1;
    tick();
    buf_we = 1'b0;
    nAssert++;
    if (buf_wack !== 1'b1 || count !== CW'(3)) begin
      nFail++;
      $display("[TB] FAIL pre_mid_reset: wack=%b count=%0d required 1 3", buf_wack, count);
    end
    rst = 1'b0; purge = 1'b1;
    tick();
    rst = 1'b1; purge = 1'b0;
    sbQ.delete();
    nAssert++;
    if ({buf_wack, id_valid, full, count, id_inst, id_pc} !== '0) begin
      nFail++;
      $display("[TB] FAIL mid_reset: wack=%b valid=%b full=%b count=%0d inst=%h pc=%h required all 0",
               buf_wack, id_valid, full, count, id_inst, id_pc);
    end
    writeWord(32'h0000_0093, 32'h1000);
    drainOne("post_reset_head_0x1000");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fill_and_full();
    test_hold_we();
    test_purge();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
